// File: rtl/pipe_controller.sv
// Control unit for the 5-stage MIPS pipeline: ID decode, per-stage control registers,
// load-use stall, branch/jump redirect and invalid-instruction trap with EPC/cause capture.
module pipe_controller #(
    parameter int unsigned        PC_W           = 32,
    parameter logic [PC_W-1:0]    EXC_VECTOR     = 32'h0000_0080,
    parameter int unsigned        CAUSE_W        = 5,
    parameter logic [CAUSE_W-1:0] CAUSE_RI       = 5'd10,
    parameter bit                 LOAD_USE_STALL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        inst_id,
    input  logic [PC_W-1:0]    pc_id,
    input  logic               id_valid,
    input  logic               zero_ex,
    input  logic               exc_ack,
    output logic               stall,
    output logic               flush_if_id,
    output logic [1:0]         pc_src,
    output logic [3:0]         ex_alu_ctrl,
    output logic [1:0]         ex_alu_a_src,
    output logic [1:0]         ex_alu_b_src,
    output logic               ex_extend,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic [1:0]         wb_data_src,
    output logic [1:0]         wb_dest_src,
    output logic [PC_W-1:0]    epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               exc_pending
);

    localparam logic [3:0] AluAdd = 4'b0000, AluSub = 4'b0001, AluAnd = 4'b0010,
                           AluOr  = 4'b0011, AluSll = 4'b0100, AluSrl = 4'b0101,
                           AluSra = 4'b0110, AluLui = 4'b0111, AluSlt = 4'b1000;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic [1:0] alu_a_src;
        logic [1:0] alu_b_src;
        logic       extend;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] data_src;
        logic [1:0] dest_src;
        logic       is_load;
        logic       is_branch;
        logic       bne;
        logic [4:0] rt;
    } idex_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] data_src;
        logic [1:0] dest_src;
    } wb_t;

    if (EXC_VECTOR[1:0] != 2'b00) begin : g_vector_check
        $error("EXC_VECTOR must be word aligned");
    end

    idex_t              idex_q, idex_d, dec;
    logic               exmem_mem_write_q;
    wb_t                exmem_wb_q, memwb_q;
    logic [PC_W-1:0]    epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               pend_q, pend_d;
    logic               dec_invalid, dec_jump, dec_uses_rt;
    logic               branch_taken, trap, load_use;
    logic [5:0]         opcode, funct;

    assign opcode = inst_id[31:26];
    assign funct  = inst_id[5:0];

    // Selects: A 00 rs / 01 shamt; B 00 rt / 01 imm; data 00 alu / 01 lw / 10 lb / 11 pc+8.
    always_comb begin
        dec         = '0;
        dec.rt      = inst_id[20:16];
        dec_invalid = 1'b0;
        dec_jump    = 1'b0;
        dec_uses_rt = 1'b0;
        if (inst_id != 32'd0) begin
            case (opcode)
                6'h00: begin
                    dec_uses_rt   = 1'b1;
                    dec.reg_write = 1'b1;
                    case (funct)
                        6'h20: dec.alu_ctrl = AluAdd;
                        6'h22: dec.alu_ctrl = AluSub;
                        6'h24: dec.alu_ctrl = AluAnd;
                        6'h25: dec.alu_ctrl = AluOr;
                        6'h2A: dec.alu_ctrl = AluSlt;
                        6'h00: begin dec.alu_ctrl = AluSll; dec.alu_a_src = 2'b01; end
                        6'h02: begin dec.alu_ctrl = AluSrl; dec.alu_a_src = 2'b01; end
                        6'h03: begin dec.alu_ctrl = AluSra; dec.alu_a_src = 2'b01; end
                        6'h08: begin dec.reg_write = 1'b0; dec_jump = 1'b1; end
                        default: begin dec.reg_write = 1'b0; dec_invalid = 1'b1; end
                    endcase
                end
                6'h02: dec_jump = 1'b1;
                6'h03: begin
                    dec_jump      = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.data_src  = 2'b11;
                    dec.dest_src  = 2'b10;
                end
                6'h04, 6'h05: begin
                    dec_uses_rt   = 1'b1;
                    dec.alu_ctrl  = AluSub;
                    dec.extend    = 1'b1;
                    dec.is_branch = 1'b1;
                    dec.bne       = opcode[0];
                end
                6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h23: begin
                    dec.alu_b_src = 2'b01;
                    dec.reg_write = 1'b1;
                    dec.dest_src  = 2'b01;
                    case (opcode)
                        6'h0A:   begin dec.alu_ctrl = AluSlt; dec.extend = 1'b1; end
                        6'h0C:   dec.alu_ctrl = AluAnd;
                        6'h0D:   dec.alu_ctrl = AluOr;
                        6'h0F:   dec.alu_ctrl = AluLui;
                        6'h20:   begin dec.extend = 1'b1; dec.is_load = 1'b1; dec.data_src = 2'b10; end
                        6'h23:   begin dec.extend = 1'b1; dec.is_load = 1'b1; dec.data_src = 2'b01; end
                        default: dec.extend = 1'b1;
                    endcase
                end
                6'h2B: begin
                    dec_uses_rt   = 1'b1;
                    dec.alu_b_src = 2'b01;
                    dec.extend    = 1'b1;
                    dec.mem_write = 1'b1;
                end
                default: dec_invalid = 1'b1;
            endcase
        end
    end

    assign branch_taken = idex_q.is_branch & (zero_ex ^ idex_q.bne);
    assign trap         = id_valid & dec_invalid & ~pend_q & ~branch_taken;
    // Invalid instructions never stall: they either trap or become a bubble.
    assign load_use = LOAD_USE_STALL & id_valid & ~dec_invalid & idex_q.is_load &
                      (idex_q.rt != 5'd0) &
                      ((idex_q.rt == inst_id[25:21]) |
                       ((idex_q.rt == inst_id[20:16]) & dec_uses_rt));

    always_comb begin
        stall       = 1'b0;
        flush_if_id = 1'b0;
        pc_src      = 2'b00;
        idex_d      = '0;
        if (reset) begin
            idex_d = '0;
        end else if (branch_taken) begin
            pc_src      = 2'b01;
            flush_if_id = 1'b1;
        end else if (trap) begin
            pc_src      = 2'b11;
            flush_if_id = 1'b1;
        end else if (load_use) begin
            stall = 1'b1;
        end else if (id_valid && !dec_invalid) begin
            idex_d = dec;
            if (dec_jump) begin
                pc_src      = 2'b10;
                flush_if_id = 1'b1;
            end
        end
    end

    always_comb begin
        epc_d   = epc_q;
        cause_d = cause_q;
        pend_d  = pend_q;
        if (trap) begin
            epc_d   = pc_id;
            cause_d = CAUSE_RI;
            pend_d  = 1'b1;
        end else if (exc_ack) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q            <= '0;
            exmem_mem_write_q <= 1'b0;
            exmem_wb_q        <= '0;
            memwb_q           <= '0;
            epc_q             <= '0;
            cause_q           <= '0;
            pend_q            <= 1'b0;
        end else begin
            idex_q            <= idex_d;
            exmem_mem_write_q <= idex_q.mem_write;
            exmem_wb_q        <= '{reg_write: idex_q.reg_write, data_src: idex_q.data_src,
                                   dest_src: idex_q.dest_src};
            memwb_q           <= exmem_wb_q;
            epc_q             <= epc_d;
            cause_q           <= cause_d;
            pend_q            <= pend_d;
        end
    end

    assign ex_alu_ctrl  = idex_q.alu_ctrl;
    assign ex_alu_a_src = idex_q.alu_a_src;
    assign ex_alu_b_src = idex_q.alu_b_src;
    assign ex_extend    = idex_q.extend;
    assign mem_write    = exmem_mem_write_q;
    assign wb_reg_write = memwb_q.reg_write;
    assign wb_data_src  = memwb_q.data_src;
    assign wb_dest_src  = memwb_q.dest_src;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign exc_pending  = pend_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed scenarios then random instruction streams, both checked
// against an instruction-level reference model (stall and no-stall builds side by side).
module tb_pipe_controller;

    typedef enum int {
        KNop, KAdd, KSub, KAnd, KOr, KSlt, KSll, KSrl, KSra, KJr, KAddi, KAndi, KOri, KSlti,
        KLui, KLw, KLb, KSw, KBeq, KBne, KJ, KJal, KBadOp, KBadFn
    } kind_t;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] asrc;
        logic [1:0] bsrc;
        logic       ext;
        logic       mw;
        logic       rw;
        logic [1:0] ds;
        logic [1:0] dd;
        logic       ld;
        logic       br;
        logic       bne;
        logic [4:0] rt;
    } ctl_t;

    typedef struct packed {
        ctl_t        idex;
        ctl_t        exmem;
        ctl_t        memwb;
        logic [31:0] epc;
        logic [4:0]  cause;
        logic        pend;
    } mst_t;

    logic        clk = 1'b0;
    logic        reset, id_valid, zero_ex, exc_ack;
    logic [31:0] inst_id, pc_id;

    logic        stall, flush_if_id, ex_extend, mem_write, wb_reg_write, exc_pending;
    logic [1:0]  pc_src, ex_alu_a_src, ex_alu_b_src, wb_data_src, wb_dest_src;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] epc;
    logic [4:0]  cause;

    logic        stall2, flush2, ext2, mw2, rw2, pend2;
    logic [1:0]  pcs2, asrc2, bsrc2, ds2, dd2;
    logic [3:0]  alu2;
    logic [31:0] epc2;
    logic [4:0]  cause2;

    always #5 clk = ~clk;

    pipe_controller #(.LOAD_USE_STALL(1'b1)) dut (
        .clk(clk), .reset(reset), .inst_id(inst_id), .pc_id(pc_id), .id_valid(id_valid),
        .zero_ex(zero_ex), .exc_ack(exc_ack), .stall(stall), .flush_if_id(flush_if_id),
        .pc_src(pc_src), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_a_src(ex_alu_a_src),
        .ex_alu_b_src(ex_alu_b_src), .ex_extend(ex_extend), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_data_src(wb_data_src), .wb_dest_src(wb_dest_src),
        .epc(epc), .cause(cause), .exc_pending(exc_pending)
    );

    pipe_controller #(.LOAD_USE_STALL(1'b0)) dut_nolus (
        .clk(clk), .reset(reset), .inst_id(inst_id), .pc_id(pc_id), .id_valid(id_valid),
        .zero_ex(zero_ex), .exc_ack(exc_ack), .stall(stall2), .flush_if_id(flush2),
        .pc_src(pcs2), .ex_alu_ctrl(alu2), .ex_alu_a_src(asrc2), .ex_alu_b_src(bsrc2),
        .ex_extend(ext2), .mem_write(mw2), .wb_reg_write(rw2), .wb_data_src(ds2),
        .wb_dest_src(dd2), .epc(epc2), .cause(cause2), .exc_pending(pend2)
    );

    int   checks = 0;
    int   errors = 0;
    bit   en_chk = 1'b0;
    mst_t m1, m2;

    logic [3:0]  obs_ctrl, obs_ex_alu;
    logic        obs_stall2, obs_mw, obs_rw, obs_pend;
    logic [31:0] obs_epc;
    logic [4:0]  obs_cause;
    logic [31:0] obs_regs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected control bundle for each instruction kind.
    function automatic ctl_t kctl(input kind_t k, input logic [4:0] rt);
        ctl_t c;
        c = '0;
        c.rt = rt;
        case (k)
            KAdd:  c.rw = 1'b1;
            KSub:  begin c.alu = 4'd1; c.rw = 1'b1; end
            KAnd:  begin c.alu = 4'd2; c.rw = 1'b1; end
            KOr:   begin c.alu = 4'd3; c.rw = 1'b1; end
            KSlt:  begin c.alu = 4'd8; c.rw = 1'b1; end
            KSll:  begin c.alu = 4'd4; c.asrc = 2'b01; c.rw = 1'b1; end
            KSrl:  begin c.alu = 4'd5; c.asrc = 2'b01; c.rw = 1'b1; end
            KSra:  begin c.alu = 4'd6; c.asrc = 2'b01; c.rw = 1'b1; end
            KAddi: begin c.bsrc = 2'b01; c.ext = 1'b1; c.rw = 1'b1; c.dd = 2'b01; end
            KAndi: begin c.alu = 4'd2; c.bsrc = 2'b01; c.rw = 1'b1; c.dd = 2'b01; end
            KOri:  begin c.alu = 4'd3; c.bsrc = 2'b01; c.rw = 1'b1; c.dd = 2'b01; end
            KSlti: begin c.alu = 4'd8; c.bsrc = 2'b01; c.ext = 1'b1; c.rw = 1'b1; c.dd = 2'b01; end
            KLui:  begin c.alu = 4'd7; c.bsrc = 2'b01; c.rw = 1'b1; c.dd = 2'b01; end
            KLw:   begin c.bsrc = 2'b01; c.ext = 1'b1; c.rw = 1'b1; c.ds = 2'b01; c.dd = 2'b01;
                         c.ld = 1'b1; end
            KLb:   begin c.bsrc = 2'b01; c.ext = 1'b1; c.rw = 1'b1; c.ds = 2'b10; c.dd = 2'b01;
                         c.ld = 1'b1; end
            KSw:   begin c.bsrc = 2'b01; c.ext = 1'b1; c.mw = 1'b1; end
            KBeq:  begin c.alu = 4'd1; c.ext = 1'b1; c.br = 1'b1; end
            KBne:  begin c.alu = 4'd1; c.ext = 1'b1; c.br = 1'b1; c.bne = 1'b1; end
            KJal:  begin c.rw = 1'b1; c.ds = 2'b11; c.dd = 2'b10; end
            default: c.rt = rt;
        endcase
        return c;
    endfunction

    function automatic bit kbad(input kind_t k);
        return k == KBadOp || k == KBadFn;
    endfunction

    function automatic bit kjump(input kind_t k);
        return k == KJ || k == KJal || k == KJr;
    endfunction

    function automatic bit kuses_rt(input kind_t k);
        return (k >= KNop && k <= KJr) || k == KBadFn || k == KSw || k == KBeq || k == KBne;
    endfunction

    function automatic logic [31:0] enc(input kind_t k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm,
                                        input logic [25:0] tgt);
        logic [5:0] op, fn;
        op = 6'h00;
        fn = 6'h00;
        case (k)
            KAdd: fn = 6'h20;  KSub: fn = 6'h22;  KAnd: fn = 6'h24;  KOr: fn = 6'h25;
            KSlt: fn = 6'h2A;  KSll: fn = 6'h00;  KSrl: fn = 6'h02;  KSra: fn = 6'h03;
            KJr:  fn = 6'h08;
            KBadFn: case (imm[1:0]) 2'd0: fn = 6'h01; 2'd1: fn = 6'h3F; 2'd2: fn = 6'h09;
                                    default: fn = 6'h21; endcase
            KAddi: op = 6'h08; KAndi: op = 6'h0C; KOri: op = 6'h0D; KSlti: op = 6'h0A;
            KLui:  op = 6'h0F; KLw:   op = 6'h23; KLb:  op = 6'h20; KSw:   op = 6'h2B;
            KBeq:  op = 6'h04; KBne:  op = 6'h05; KJ:   op = 6'h02; KJal:  op = 6'h03;
            KBadOp: case (imm[2:0]) 3'd0: op = 6'h01; 3'd1: op = 6'h06; 3'd2: op = 6'h07;
                                    3'd3: op = 6'h10; 3'd4: op = 6'h11; 3'd5: op = 6'h2F;
                                    3'd6: op = 6'h3F; default: op = 6'h1F; endcase
            default: op = 6'h00;
        endcase
        if (k == KNop) return 32'd0;
        if (k == KJ || k == KJal) return {op, tgt};
        if (op == 6'h00) return {op, rs, rt, rd, imm[10:6], fn};
        return {op, rs, rt, imm};
    endfunction

    // One cycle of the pipeline at instruction level: resolve this cycle's event, then advance.
    task automatic mstep(input mst_t s, input bit lus, input bit rst, input kind_t k,
                         input logic [31:0] inst, input logic [31:0] pc, input bit v, input bit z,
                         input bit ack, output mst_t n, output logic [3:0] comb);
        bit   taken, ok, bad, haz, trapped;
        ctl_t nid;
        n       = s;
        comb    = 4'b0000;
        nid     = '0;
        trapped = 1'b0;
        if (rst) begin
            n = '0;
            return;
        end
        taken = s.idex.br && (z != s.idex.bne);
        bad   = v && kbad(k);
        ok    = v && !kbad(k);
        haz   = lus && ok && s.idex.ld && s.idex.rt != 5'd0 &&
                (s.idex.rt == inst[25:21] || (s.idex.rt == inst[20:16] && kuses_rt(k)));
        if (taken) begin
            comb = 4'b0101;
        end else if (bad && !s.pend) begin
            comb    = 4'b0111;
            trapped = 1'b1;
            n.epc   = pc;
            n.cause = 5'd10;
            n.pend  = 1'b1;
        end else if (haz) begin
            comb = 4'b1000;
        end else if (ok) begin
            nid = kctl(k, inst[20:16]);
            if (kjump(k)) comb = 4'b0110;
        end
        if (!trapped && ack) n.pend = 1'b0;
        n.idex  = nid;
        n.exmem = s.idex;
        n.memwb = s.exmem;
    endtask

    task automatic step(input bit rst, input kind_t k, input logic [31:0] inst,
                        input logic [31:0] pc, input bit v, input bit z, input bit ack);
        mst_t       n1, n2;
        logic [3:0] c1, c2;
        reset    = rst;
        inst_id  = inst;
        pc_id    = pc;
        id_valid = v;
        zero_ex  = z;
        exc_ack  = ack;
        #3;
        mstep(m1, 1'b1, rst, k, inst, pc, v, z, ack, n1, c1);
        mstep(m2, 1'b0, rst, k, inst, pc, v, z, ack, n2, c2);
        obs_ctrl   = {stall, flush_if_id, pc_src};
        obs_stall2 = stall2;
        obs_ex_alu = ex_alu_ctrl;
        obs_mw     = mem_write;
        obs_rw     = wb_reg_write;
        obs_epc    = epc;
        obs_cause  = cause;
        obs_pend   = exc_pending;
        obs_regs   = {ex_alu_ctrl, ex_alu_a_src, ex_alu_b_src, ex_extend, mem_write,
                      wb_reg_write, wb_data_src, wb_dest_src, epc[12:0], cause, exc_pending};
        if (en_chk) begin
            chk("ctrl", 64'(obs_ctrl), 64'(c1));
            chk("ex", 64'({ex_alu_ctrl, ex_alu_a_src, ex_alu_b_src, ex_extend}),
                64'({m1.idex.alu, m1.idex.asrc, m1.idex.bsrc, m1.idex.ext}));
            chk("memwb", 64'({mem_write, wb_reg_write, wb_data_src, wb_dest_src}),
                64'({m1.exmem.mw, m1.memwb.rw, m1.memwb.ds, m1.memwb.dd}));
            chk("exc", 64'({epc, cause, exc_pending}), 64'({m1.epc, m1.cause, m1.pend}));
            chk("ctrl_nolus", 64'({stall2, flush2, pcs2}), 64'(c2));
            chk("ex_nolus", 64'({alu2, asrc2, bsrc2, ext2}),
                64'({m2.idex.alu, m2.idex.asrc, m2.idex.bsrc, m2.idex.ext}));
            chk("memwb_nolus", 64'({mw2, rw2, ds2, dd2}),
                64'({m2.exmem.mw, m2.memwb.rw, m2.memwb.ds, m2.memwb.dd}));
            chk("exc_nolus", 64'({epc2, cause2, pend2}), 64'({m2.epc, m2.cause, m2.pend}));
        end
        m1 = n1;
        m2 = n2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] lw8, sub8, beq, jal, bne, sw;
        kind_t       k;
        logic [31:0] ins;
        m1 = '0;
        m2 = '0;
        lw8  = enc(KLw, 5'd9, 5'd8, 5'd0, 16'd4, 26'd0);
        sub8 = enc(KSub, 5'd8, 5'd10, 5'd11, 16'd0, 26'd0);
        beq  = enc(KBeq, 5'd1, 5'd2, 5'd0, 16'd8, 26'd0);
        jal  = enc(KJal, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0123456);
        bne  = enc(KBne, 5'd1, 5'd2, 5'd0, 16'hFFF0, 26'd0);
        sw   = enc(KSw, 5'd3, 5'd4, 5'd0, 16'd12, 26'd0);
        @(posedge clk);
        #1;

        // Reset with garbage in ID, then release with a bubble.
        step(1'b1, KBadOp, 32'hDEADBEEF, 32'h100, 1'b1, 1'b1, 1'b0);
        en_chk = 1'b1;
        step(1'b1, KBadOp, 32'hDEADBEEF, 32'h104, 1'b1, 1'b1, 1'b0);
        step(1'b0, KBadOp, 32'hDEADBEEF, 32'h108, 1'b0, 1'b0, 1'b0);
        chk("post_reset_comb", 64'(obs_ctrl), 64'd0);
        chk("post_reset_regs", 64'(obs_regs), 64'd0);

        // First ADD: EX next cycle, WB three cycles later.
        step(1'b0, KAdd, 32'h012A4020, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        chk("add_ex_alu", 64'(obs_ex_alu), 64'h0);
        step(1'b0, KNop, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("add_wb_write", 64'(obs_rw), 64'd1);

        // Load-use: LW $t0 then SUB reading $t0.
        step(1'b0, KLw, lw8, 32'h10, 1'b1, 1'b0, 1'b0);
        step(1'b0, KSub, sub8, 32'h14, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 64'(obs_ctrl), 64'b1000);
        chk("lu_nostall_build", 64'(obs_stall2), 64'd0);
        step(1'b0, KSub, sub8, 32'h14, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_one_cycle", 64'(obs_ctrl), 64'd0);
        chk("lu_bubble_in_ex", 64'(obs_ex_alu), 64'h0);
        step(1'b0, KNop, 32'h0, 32'h18, 1'b0, 1'b0, 1'b0);
        chk("lu_sub_late_ex", 64'(obs_ex_alu), 64'h1);

        // Taken BEQ in EX beats JAL in ID.
        step(1'b0, KBeq, beq, 32'h20, 1'b1, 1'b0, 1'b0);
        step(1'b0, KJal, jal, 32'h24, 1'b1, 1'b1, 1'b0);
        chk("beq_beats_jal", 64'(obs_ctrl), 64'b0101);
        step(1'b0, KNop, 32'h0, 32'h28, 1'b0, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h2C, 1'b0, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h30, 1'b0, 1'b0, 1'b0);
        chk("jal_discarded", 64'(obs_rw), 64'd0);

        // Trap, suppressed nested trap, acknowledge.
        step(1'b0, KBadOp, 32'hFC000000, 32'h40, 1'b1, 1'b0, 1'b0);
        chk("trap_redirect", 64'(obs_ctrl), 64'b0111);
        step(1'b0, KBadOp, 32'hFC000000, 32'h44, 1'b1, 1'b0, 1'b0);
        chk("nested_no_redirect", 64'(obs_ctrl), 64'd0);
        chk("trap_capture", 64'({obs_epc, obs_cause, obs_pend}), 64'({32'h40, 5'd10, 1'b1}));
        step(1'b0, KNop, 32'h0, 32'h80, 1'b0, 1'b0, 1'b1);
        chk("nested_no_capture", 64'(obs_epc), 64'h40);
        step(1'b0, KNop, 32'h0, 32'h84, 1'b0, 1'b0, 1'b0);
        chk("ack_clears", 64'(obs_pend), 64'd0);

        // BNE taken on zero=0, not taken on zero=1.
        step(1'b0, KBne, bne, 32'h50, 1'b1, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h54, 1'b0, 1'b0, 1'b0);
        chk("bne_taken", 64'(obs_ctrl), 64'b0101);
        step(1'b0, KBne, bne, 32'h58, 1'b1, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h5C, 1'b0, 1'b1, 1'b0);
        chk("bne_not_taken", 64'(obs_ctrl), 64'd0);

        // Reset while SW sits in ID/EX and a trap is pending.
        step(1'b0, KBadFn, 32'h0000_0001, 32'h99C, 1'b1, 1'b0, 1'b0);
        step(1'b0, KSw, sw, 32'h9A0, 1'b1, 1'b0, 1'b0);
        step(1'b1, KNop, 32'h0, 32'h9A4, 1'b0, 1'b0, 1'b0);
        step(1'b0, KNop, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_sw_dropped", 64'(obs_mw), 64'd0);
        chk("rst_exc_cleared", 64'({obs_epc, obs_pend}), 64'd0);
        step(1'b0, KNop, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0);
        chk("rst_sw_dropped_later", 64'(obs_mw), 64'd0);

        // Random streams over a small register set to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            k   = kind_t'($urandom_range(0, 23));
            ins = enc(k, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(1, 31)), 16'($urandom), 26'($urandom));
            step(($urandom_range(0, 99) == 0), k, ins, $urandom & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
